// File: rtl/pc_stack.sv
// pc_stack: parametrised program counter with relative branch and a
// hardware call/return stack.
//
// The PC is a plain register advanced by the op the control decoder supplies
// each cycle. CALL pushes the wrapped return address (result+1) and jumps to
// data. RETURN pops the most recent return address. An attempt to push onto a
// full stack or pop from an empty one changes nothing except the sticky err
// flag, which only CLRERR or reset clears.
//
// Ports:
//   clk      system clock, all state updates on posedge
//   reset_n  asynchronous active-low reset (result=RESET_ADDR, sp=0, err=0)
//   en       operation enable; 0 holds every piece of state
//   op       000 HOLD, 001 INCR, 010 LOAD, 011 BRANCH, 100 CALL,
//            101 RETURN, 110 CLRERR, 111 reserved (HOLD)
//   data     absolute target (LOAD/CALL) or two's-complement offset (BRANCH)
//   result   current PC, registered
//   sp       number of valid stack entries, 0..DEPTH
//   full     sp == DEPTH
//   empty    sp == 0
//   err      sticky stack overflow/underflow flag, registered
module pc_stack #(
    parameter int                 WIDTH      = 8,
    parameter int                 DEPTH      = 4,
    parameter logic [WIDTH-1:0]   RESET_ADDR = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic [2:0]                    op,
    input  logic [WIDTH-1:0]              data,
    output logic [WIDTH-1:0]              result,
    output logic [$clog2(DEPTH+1)-1:0]    sp,
    output logic                          full,
    output logic                          empty,
    output logic                          err
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WIDTH-1:0] PC_ONE    = WIDTH'(1);
    localparam logic [SPW-1:0]   SP_ONE    = SPW'(1);
    localparam logic [SPW-1:0]   SP_DEPTH  = SPW'(DEPTH);

    localparam logic [2:0] OP_INCR   = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RETURN = 3'b101;
    localparam logic [2:0] OP_CLRERR = 3'b110;

    logic [WIDTH-1:0] result_reg, result_next;
    logic [SPW-1:0]   sp_reg, sp_next;
    logic             err_reg, err_next;

    // Return-address storage; contents are never reset, sp says what is valid.
    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic             push_en;
    logic [WIDTH-1:0] ret_addr;
    logic [SPW-1:0]   sp_dec;
    logic [IDXW-1:0]  push_idx;
    logic [IDXW-1:0]  pop_idx;
    logic             full_int;
    logic             empty_int;

    assign full_int  = (sp_reg == SP_DEPTH);
    assign empty_int = (sp_reg == '0);
    assign ret_addr  = result_reg + PC_ONE;   // wraps, so a CALL at all-ones pushes 0
    assign sp_dec    = sp_reg - SP_ONE;
    assign push_idx  = sp_reg[IDXW-1:0];      // only used when !full, so sp < DEPTH
    assign pop_idx   = sp_dec[IDXW-1:0];      // only used when !empty

    always_comb begin
        result_next = result_reg;
        sp_next     = sp_reg;
        err_next    = err_reg;
        push_en     = 1'b0;
        if (en) begin
            case (op)
                OP_INCR:   result_next = result_reg + PC_ONE;
                OP_LOAD:   result_next = data;
                // Two's-complement offset: plain modular add moves either way.
                OP_BRANCH: result_next = result_reg + data;
                OP_CALL: begin
                    if (full_int) begin
                        err_next = 1'b1;
                    end else begin
                        push_en     = 1'b1;
                        sp_next     = sp_reg + SP_ONE;
                        result_next = data;
                    end
                end
                OP_RETURN: begin
                    if (empty_int) begin
                        err_next = 1'b1;
                    end else begin
                        sp_next     = sp_dec;
                        result_next = stack_mem[pop_idx];
                    end
                end
                OP_CLRERR: err_next = 1'b0;
                default:   ;   // HOLD and reserved encoding
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_reg <= RESET_ADDR;
            sp_reg     <= '0;
            err_reg    <= 1'b0;
        end else begin
            result_reg <= result_next;
            sp_reg     <= sp_next;
            err_reg    <= err_next;
        end
    end

    // Gated by reset_n so an edge seen while reset is held cannot write.
    always_ff @(posedge clk) begin
        if (push_en && reset_n) begin
            stack_mem[push_idx] <= ret_addr;
        end
    end

    assign result = result_reg;
    assign sp     = sp_reg;
    assign full   = full_int;
    assign empty  = empty_int;
    assign err    = err_reg;

endmodule

// File: tb/tb_pc_stack.sv
// Testbench for pc_stack (WIDTH=8, DEPTH=4, RESET_ADDR=8'h10).
// The driver issues one op per cycle, updates a queue-based reference model and
// pushes the expected post-edge state into a scoreboard queue. A separate
// monitor pops one entry after every posedge and compares all outputs.
module tb_pc_stack;

    localparam int         W     = 8;
    localparam int         D     = 4;
    localparam logic [7:0] RADDR = 8'h10;

    localparam logic [2:0] HOLD = 3'd0, INCR = 3'd1, LOAD = 3'd2, BRANCH = 3'd3,
                           CALL = 3'd4, RET  = 3'd5, CLRERR = 3'd6, RSVD = 3'd7;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] data = '0;
    logic [W-1:0] result;
    logic [2:0]   sp;
    logic         full, empty, err;

    pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_ADDR(RADDR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .op      (op),
        .data    (data),
        .result  (result),
        .sp      (sp),
        .full    (full),
        .empty   (empty),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        int         depth;
        logic       err;
        logic [2:0] op;
        logic       en;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the stack is simply a queue of return addresses.
    logic [7:0] m_pc;
    logic [7:0] m_stack[$];
    logic       m_err;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    task automatic check_val(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] pc, input int depth, input logic e);
        check_val({tag, ".result"}, int'(result), int'(pc));
        check_val({tag, ".sp"},     int'(sp),     depth);
        check_val({tag, ".full"},   int'(full),   (depth == D) ? 1 : 0);
        check_val({tag, ".empty"},  int'(empty),  (depth == 0) ? 1 : 0);
        check_val({tag, ".err"},    int'(err),    int'(e));
    endtask

    task automatic model_step(input logic e, input logic [2:0] o, input logic [7:0] d);
        if (!e) return;
        case (o)
            INCR:   m_pc = m_pc + 8'd1;
            LOAD:   m_pc = d;
            BRANCH: m_pc = m_pc + d;
            CALL: begin
                if (m_stack.size() == D) m_err = 1'b1;
                else begin
                    m_stack.push_back(m_pc + 8'd1);
                    m_pc = d;
                end
            end
            RET: begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else m_pc = m_stack.pop_back();
            end
            CLRERR: m_err = 1'b0;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic e, input logic [2:0] o, input logic [7:0] d);
        exp_t x;
        @(negedge clk);
        en = e; op = o; data = d;
        model_step(e, o, d);
        x.pc = m_pc; x.depth = m_stack.size(); x.err = m_err;
        x.op = o; x.en = e; x.data = d;
        exp_q.push_back(x);
    endtask

    // Reset asserted mid-cycle with whatever op is currently driven; the op
    // must be discarded. Outputs are checked asynchronously before any edge.
    task automatic do_reset(input logic e, input logic [2:0] o, input logic [7:0] d);
        @(negedge clk);
        en = e; op = o; data = d;
        #2 reset_n = 1'b0;
        #1;
        m_pc = RADDR; m_stack.delete(); m_err = 1'b0;
        check_all("async_reset", RADDR, 0, 1'b0);
        $display("txn reset: result=%02h sp=%0d err=%0b", result, sp, err);
        @(negedge clk);
        en = 1'b0;
        reset_n = 1'b1;
    endtask

    // Monitor: every state update is observable right after the edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            txn++;
            $display("txn %0d: en=%0b op=%0d data=%02h -> result=%02h sp=%0d err=%0b (exp %02h/%0d/%0b)",
                     txn, x.en, x.op, x.data, result, sp, err, x.pc, x.depth, x.err);
            check_all($sformatf("txn%0d", txn), x.pc, x.depth, x.err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pc = RADDR; m_err = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset / INCR / wrap
        do_reset(1'b0, HOLD, 8'h00);
        do_op(1, LOAD, 8'hFE);
        do_op(1, INCR, 8'h00);
        do_op(1, INCR, 8'h00);
        do_op(1, INCR, 8'h00);

        // BRANCH both directions
        do_op(1, LOAD, 8'h40);
        do_op(1, BRANCH, 8'h05);
        do_op(1, BRANCH, 8'hFB);
        do_op(1, LOAD, 8'h50);
        do_op(1, BRANCH, 8'hC0);

        // Nested call/return
        do_op(1, LOAD, 8'h20);
        do_op(1, CALL, 8'h80);
        do_op(1, CALL, 8'h90);
        do_op(1, CALL, 8'hA0);
        repeat (3) do_op(1, RET, 8'h00);

        // Overflow, including a CALL at all-ones pushing 0
        do_op(1, LOAD, 8'hFF);
        do_op(1, CALL, 8'h01);
        do_op(1, CALL, 8'h02);
        do_op(1, CALL, 8'h03);
        do_op(1, CALL, 8'h04);
        do_op(1, CALL, 8'hEE);
        do_op(1, CALL, 8'hEF);
        do_op(1, RET, 8'h00);
        do_op(1, CLRERR, 8'h00);
        repeat (3) do_op(1, RET, 8'h00);

        // Underflow and enable
        do_op(1, RET, 8'h00);
        do_op(0, CALL, 8'h77);
        do_op(0, CLRERR, 8'h00);
        do_op(0, RET, 8'h00);
        do_op(1, RSVD, 8'h33);
        do_op(1, CLRERR, 8'h00);

        // Reset during a stack sequence, with a CALL pending at the edge
        do_op(1, CALL, 8'h60);
        do_op(1, CALL, 8'h70);
        do_reset(1'b1, CALL, 8'h88);
        do_op(1, RET, 8'h00);
        do_op(1, CLRERR, 8'h00);

        // Randomised traffic, biased toward the stack ops
        for (int i = 0; i < 400; i++) begin
            logic [2:0] o;
            logic       e;
            int         r;
            r = $urandom_range(0, 99);
            if (r < 25)      o = CALL;
            else if (r < 50) o = RET;
            else             o = 3'($urandom_range(0, 7));
            e = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 99) == 0)
                do_reset(e, o, 8'($urandom));
            else
                do_op(e, o, 8'($urandom));
        end

        begin
            int budget = 0;
            while (exp_q.size() != 0 && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (exp_q.size() != 0) begin
                errors++;
                checks++;
                $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
